// File: rtl/tower_shop_ctrl_pkg.sv
// Shared types and HUD geometry for the tower shop controller.
// Button/start-rect geometry is also used by the sprite renderer.
package tower_shop_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } shop_state_t;

  localparam logic [7:0] KEY_LCLICK = 8'h01;
  localparam logic [7:0] KEY_RCLICK = 8'h02;
  localparam logic [7:0] KEY_ESC    = 8'h29;

  localparam int SHOP_X0   = 484;
  localparam int SHOP_Y0   = 90;
  localparam int BTN_W     = 20;
  localparam int BTN_H     = 20;
  localparam int BTN_PITCH = 30;

  localparam int START_X0 = 480;
  localparam int START_Y0 = 402;
  localparam int START_X1 = 622;
  localparam int START_Y1 = 450;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tower_shop_ctrl_if.sv
// Shop controller bus: cursor/key/money inputs and
// purchase/placement results toward map and money bank.
interface tower_shop_ctrl_if
  import tower_shop_ctrl_pkg::*;
#(
  parameter int NUM_TYPES  = 4,
  parameter int MONEY_W    = 10,
  parameter int MAX_TOWERS = 16
);
  localparam int TW = idx_w(NUM_TYPES);
  localparam int CW = $clog2(MAX_TOWERS + 1);

  logic [9:0]         MouseX;
  logic [9:0]         MouseY;
  logic [7:0]         keycode;
  logic [MONEY_W-1:0] money;
  logic               round_active;
  logic               place_ok;

  logic               armed;
  logic [TW-1:0]      sel_type;
  logic               spend_valid;
  logic [MONEY_W-1:0] spend_amt;
  logic               deny;
  logic               start_round;
  logic [CW-1:0]      tower_count;

  modport master (
    output MouseX, MouseY, keycode,
    output money, round_active, place_ok,
    input  armed, sel_type,
    input  spend_valid, spend_amt,
    input  deny, start_round, tower_count
  );

  modport slave (
    input  MouseX, MouseY, keycode,
    input  money, round_active, place_ok,
    output armed, sel_type,
    output spend_valid, spend_amt,
    output deny, start_round, tower_count
  );

endinterface

// File: rtl/tower_shop_ctrl_rect_hit.sv
// Point-in-rectangle test, inclusive bounds,
// compared at 11 bits so edge-of-screen bounds never wrap.
module tower_shop_ctrl_rect_hit #(
  parameter int X0 = 0,
  parameter int Y0 = 0,
  parameter int X1 = 0,
  parameter int Y1 = 0
) (
  input  logic [9:0] px,
  input  logic [9:0] py,
  output logic       hit
);
  localparam logic [10:0] LX0 = 11'(X0);
  localparam logic [10:0] LY0 = 11'(Y0);
  localparam logic [10:0] LX1 = 11'(X1);
  localparam logic [10:0] LY1 = 11'(Y1);

  logic [10:0] x;
  logic [10:0] y;

  assign x = {1'b0, px};
  assign y = {1'b0, py};

  assign hit = (x >= LX0) && (x <= LX1) &&
               (y >= LY0) && (y <= LY1);

endmodule

// File: rtl/tower_shop_ctrl.sv
// Tower shop controller: decodes HUD clicks, arms placement,
// and issues spend requests when placement commits.
module tower_shop_ctrl
  import tower_shop_ctrl_pkg::*;
#(
  parameter int NUM_TYPES  = 4,
  parameter int MONEY_W    = 10,
  parameter logic [NUM_TYPES*MONEY_W-1:0] COSTS =
    {10'd250, 10'd500, 10'd350, 10'd200},
  parameter int MAX_TOWERS = 16
) (
  input logic         Clk,
  input logic         reset,
  tower_shop_ctrl_if.slave bus
);
  localparam int TW = idx_w(NUM_TYPES);
  localparam int CW = $clog2(MAX_TOWERS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_TOWERS);

  shop_state_t state_q;
  shop_state_t state_d;

  logic [7:0] key_q;
  logic       lclick;
  logic       cancel;

  logic [NUM_TYPES:0] hit;
  logic               btn_any;
  logic [TW-1:0]      btn_idx;
  logic               start_hit;

  logic [MONEY_W-1:0] cost_tbl [NUM_TYPES];
  logic [MONEY_W-1:0] btn_cost;
  logic [MONEY_W-1:0] sel_cost;
  logic               room;
  logic               afford;
  logic               drop;

  logic [TW-1:0]      sel_q, sel_d;
  logic               spend_q, spend_d;
  logic [MONEY_W-1:0] amt_q, amt_d;
  logic               deny_q, deny_d;
  logic               start_q, start_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  for (genvar k = 0; k < NUM_TYPES; k++) begin : g_btn
    tower_shop_ctrl_rect_hit #(
      .X0(SHOP_X0),
      .Y0(SHOP_Y0 + k*BTN_PITCH),
      .X1(SHOP_X0 + BTN_W),
      .Y1(SHOP_Y0 + k*BTN_PITCH + BTN_H)
    ) u_hit (
      .px (bus.MouseX),
      .py (bus.MouseY),
      .hit(hit[k])
    );
    assign cost_tbl[k] = COSTS[k*MONEY_W +: MONEY_W];
  end

  tower_shop_ctrl_rect_hit #(
    .X0(START_X0),
    .Y0(START_Y0),
    .X1(START_X1),
    .Y1(START_Y1)
  ) u_start (
    .px (bus.MouseX),
    .py (bus.MouseY),
    .hit(hit[NUM_TYPES])
  );

  assign start_hit = hit[NUM_TYPES];

  // Descending scan so the lowest overlapping button wins.
  always_comb begin
    btn_any = 1'b0;
    btn_idx = '0;
    for (int k = NUM_TYPES - 1; k >= 0; k--) begin
      if (hit[k]) begin
        btn_any = 1'b1;
        btn_idx = TW'(k);
      end
    end
  end

  assign lclick = (bus.keycode == KEY_LCLICK) &&
                  (key_q != KEY_LCLICK);
  assign cancel = ((bus.keycode == KEY_RCLICK) &&
                   (key_q != KEY_RCLICK)) ||
                  ((bus.keycode == KEY_ESC) &&
                   (key_q != KEY_ESC));

  assign btn_cost = cost_tbl[btn_idx];
  assign sel_cost = cost_tbl[sel_q];
  assign room     = cnt_q < CNT_MAX;
  assign afford   = (bus.money >= btn_cost) && room;
  assign drop     = bus.money < sel_cost;

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (lclick && btn_any && afford) state_d = ARMED;
      end
      ARMED: begin
        if (bus.place_ok || cancel || drop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_d   = sel_q;
    spend_d = 1'b0;
    amt_d   = amt_q;
    deny_d  = 1'b0;
    start_d = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (lclick && btn_any) begin
          if (afford) sel_d  = btn_idx;
          else        deny_d = 1'b1;
        end else if (lclick && start_hit && !bus.round_active) begin
          start_d = 1'b1;
        end
      end
      ARMED: begin
        if (bus.place_ok) begin
          spend_d = 1'b1;
          amt_d   = sel_cost;
          if (room) cnt_d = cnt_q + CW'(1);
        end else if (cancel) begin
          sel_d = sel_q;
        end else if (drop) begin
          deny_d = 1'b1;
        end else if (lclick && btn_any) begin
          if (afford) sel_d  = btn_idx;
          else        deny_d = 1'b1;
        end
      end
      default: sel_d = sel_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      key_q   <= '0;
      sel_q   <= '0;
      spend_q <= 1'b0;
      amt_q   <= '0;
      deny_q  <= 1'b0;
      start_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      key_q   <= bus.keycode;
      sel_q   <= sel_d;
      spend_q <= spend_d;
      amt_q   <= amt_d;
      deny_q  <= deny_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.armed       = (state_q == ARMED);
  assign bus.sel_type    = sel_q;
  assign bus.spend_valid = spend_q;
  assign bus.spend_amt   = amt_q;
  assign bus.deny        = deny_q;
  assign bus.start_round = start_q;
  assign bus.tower_count = cnt_q;

endmodule

// File: tb/tb_tower_shop_ctrl.sv
// Directed and randomized bench for tower_shop_ctrl
// against a rule-level reference model.
module tb_tower_shop_ctrl;

  logic Clk = 1'b0;
  logic reset;

  always #5 Clk = ~Clk;

  tower_shop_ctrl_if #(
    .NUM_TYPES (4),
    .MONEY_W   (10),
    .MAX_TOWERS(16)
  ) bus ();

  tower_shop_ctrl dut (
    .Clk  (Clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int cost_tbl [4] = '{200, 350, 500, 250};

  bit         m_armed;
  int         m_sel;
  int         m_cnt;
  int         m_amt;
  logic [7:0] m_prev;
  bit         e_spend;
  bit         e_deny;
  bit         e_start;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic drive(int x, int y, logic [7:0] key,
                       int money, bit ra, bit pok);
    bus.MouseX       = 10'(x);
    bus.MouseY       = 10'(y);
    bus.keycode      = key;
    bus.money        = 10'(money);
    bus.round_active = ra;
    bus.place_ok     = pok;
  endtask

  function automatic int button_at(int x, int y);
    int dy;
    if (x < 484 || x > 504) return -1;
    dy = y - 90;
    if (dy < 0) return -1;
    if (dy / 30 >= 4) return -1;
    if (dy % 30 > 20) return -1;
    return dy / 30;
  endfunction

  function automatic bit in_start(int x, int y);
    return x >= 480 && x <= 622 && y >= 402 && y <= 450;
  endfunction

  // Expected state after the coming edge, from the shop rules.
  task automatic model_step();
    int  x, y, k, money;
    bit  l, c, ok;
    logic [7:0] key;
    e_spend = 0;
    e_deny  = 0;
    e_start = 0;
    if (reset) begin
      m_armed = 0; m_sel = 0; m_cnt = 0;
      m_amt = 0; m_prev = 8'h00;
      return;
    end
    x = int'(bus.MouseX);
    y = int'(bus.MouseY);
    key = bus.keycode;
    money = int'(bus.money);
    l = (key == 8'h01) && (m_prev != 8'h01);
    c = ((key == 8'h02) && (m_prev != 8'h02)) ||
        ((key == 8'h29) && (m_prev != 8'h29));
    k = button_at(x, y);
    ok = (k >= 0) && (money >= cost_tbl[k]) && (m_cnt < 16);
    if (!m_armed) begin
      if (l && k >= 0) begin
        if (ok) begin m_armed = 1; m_sel = k; end
        else e_deny = 1;
      end else if (l && in_start(x, y) && !bus.round_active) begin
        e_start = 1;
      end
    end else if (bus.place_ok) begin
      e_spend = 1;
      m_amt = cost_tbl[m_sel];
      if (m_cnt < 16) m_cnt++;
      m_armed = 0;
    end else if (c) begin
      m_armed = 0;
    end else if (money < cost_tbl[m_sel]) begin
      m_armed = 0;
      e_deny = 1;
    end else if (l && k >= 0) begin
      if (ok) m_sel = k;
      else e_deny = 1;
    end
    m_prev = key;
  endtask

  task automatic check_all();
    chk("armed", 32'(bus.armed), 32'(m_armed));
    if (m_armed) chk("sel_type", 32'(bus.sel_type), 32'(m_sel));
    chk("spend_valid", 32'(bus.spend_valid), 32'(e_spend));
    chk("spend_amt", 32'(bus.spend_amt), 32'(m_amt));
    chk("deny", 32'(bus.deny), 32'(e_deny));
    chk("start_round", 32'(bus.start_round), 32'(e_start));
    chk("tower_count", 32'(bus.tower_count), 32'(m_cnt));
  endtask

  task automatic cyc();
    model_step();
    @(posedge Clk);
    #1;
    check_all();
  endtask

  int deny_seen;
  int rx, ry, rk, rmoney;
  logic [7:0] rkey;

  initial begin
    reset = 1'b1;
    drive(0, 0, 8'h00, 0, 0, 0);
    cyc(); cyc();
    chk("rst_armed", 32'(bus.armed), 0);
    chk("rst_count", 32'(bus.tower_count), 0);
    chk("rst_amt", 32'(bus.spend_amt), 0);
    reset = 1'b0;

    // 1: buy type 0 and place it
    drive(494, 100, 8'h00, 300, 0, 0); cyc();
    drive(494, 100, 8'h01, 300, 0, 0); cyc();
    chk("t1_armed", 32'(bus.armed), 1);
    chk("t1_sel", 32'(bus.sel_type), 0);
    drive(494, 100, 8'h00, 300, 0, 1); cyc();
    chk("t1_spend", 32'(bus.spend_valid), 1);
    chk("t1_amt", 32'(bus.spend_amt), 200);
    chk("t1_count", 32'(bus.tower_count), 1);
    chk("t1_idle", 32'(bus.armed), 0);
    drive(494, 100, 8'h00, 300, 0, 0); cyc();
    chk("t1_pulse", 32'(bus.spend_valid), 0);
    chk("t1_hold", 32'(bus.spend_amt), 200);

    // 2: unaffordable button, held click
    deny_seen = 0;
    drive(494, 160, 8'h01, 300, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bus.deny) deny_seen++;
      chk("t2_armed", 32'(bus.armed), 0);
    end
    chk("t2_one_deny", 32'(deny_seen), 1);
    drive(494, 160, 8'h00, 300, 0, 0); cyc();

    // 3: place beats same-cycle ESC
    drive(494, 130, 8'h01, 500, 0, 0); cyc();
    chk("t3_sel", 32'(bus.sel_type), 1);
    drive(494, 130, 8'h00, 500, 0, 0); cyc();
    drive(494, 130, 8'h29, 500, 0, 1); cyc();
    chk("t3_spend", 32'(bus.spend_valid), 1);
    chk("t3_amt", 32'(bus.spend_amt), 350);
    drive(494, 130, 8'h00, 500, 0, 0); cyc();

    // 4: balance drops below armed cost
    drive(494, 190, 8'h01, 300, 0, 0); cyc();
    chk("t4_sel", 32'(bus.sel_type), 3);
    drive(494, 190, 8'h00, 300, 0, 0); cyc();
    drive(494, 190, 8'h00, 240, 0, 0); cyc();
    chk("t4_armed", 32'(bus.armed), 0);
    chk("t4_deny", 32'(bus.deny), 1);
    chk("t4_nospend", 32'(bus.spend_valid), 0);

    // 5: start-round button
    drive(550, 420, 8'h01, 1000, 0, 0); cyc();
    chk("t5_start", 32'(bus.start_round), 1);
    drive(550, 420, 8'h00, 1000, 1, 0); cyc();
    chk("t5_pulse", 32'(bus.start_round), 0);
    drive(550, 420, 8'h01, 1000, 1, 0); cyc();
    chk("t5_active", 32'(bus.start_round), 0);
    drive(494, 100, 8'h00, 1000, 0, 0); cyc();
    drive(494, 100, 8'h01, 1000, 0, 0); cyc();
    drive(550, 420, 8'h00, 1000, 0, 0); cyc();
    drive(550, 420, 8'h01, 1000, 0, 0); cyc();
    chk("t5_armed_start", 32'(bus.start_round), 0);
    chk("t5_still_armed", 32'(bus.armed), 1);
    drive(550, 420, 8'h02, 1000, 0, 0); cyc();
    chk("t5_cancel", 32'(bus.armed), 0);

    // 6: fill the map, then lockout and reset
    for (int i = 0; i < 14; i++) begin
      drive(494, 100, 8'h01, 1000, 0, 0); cyc();
      drive(494, 100, 8'h00, 1000, 0, 1); cyc();
    end
    drive(494, 100, 8'h00, 1000, 0, 0); cyc();
    chk("t6_count", 32'(bus.tower_count), 16);
    drive(494, 100, 8'h01, 1000, 0, 0); cyc();
    chk("t6_deny", 32'(bus.deny), 1);
    chk("t6_locked", 32'(bus.armed), 0);
    reset = 1'b1;
    drive(494, 100, 8'h00, 1000, 0, 0); cyc();
    reset = 1'b0;
    drive(494, 100, 8'h01, 1000, 0, 0); cyc();
    chk("t6_rearmed", 32'(bus.armed), 1);
    reset = 1'b1;
    drive(494, 100, 8'h00, 1000, 0, 1); cyc();
    chk("t6_rst_armed", 32'(bus.armed), 0);
    chk("t6_rst_spend", 32'(bus.spend_valid), 0);
    chk("t6_rst_count", 32'(bus.tower_count), 0);
    reset = 1'b0;

    // randomized traffic
    rkey = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          rk = int'($urandom_range(0, 3));
          rx = 481 + int'($urandom_range(0, 26));
          ry = 87 + rk * 30 + int'($urandom_range(0, 26));
        end
        2: begin
          rx = 476 + int'($urandom_range(0, 150));
          ry = 398 + int'($urandom_range(0, 56));
        end
        default: begin
          rx = int'($urandom_range(0, 1023));
          ry = int'($urandom_range(0, 1023));
        end
      endcase
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 5))
          0, 1: rkey = 8'h01;
          2:    rkey = 8'h02;
          3:    rkey = 8'h29;
          4:    rkey = 8'h55;
          default: rkey = 8'h00;
        endcase
      end
      rmoney = ($urandom_range(0, 3) == 0) ?
               int'($urandom_range(0, 1023)) :
               int'($urandom_range(150, 600));
      reset = ($urandom_range(0, 299) == 0);
      drive(rx, ry, rkey, rmoney,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 4) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
